csa_sbox_collect: RTL and testbench

//  Downstream stage of the seven CSA stream-cipher s-boxes (5-bit in, 2-bit out each).

---
 rtl/csa_pkg.sv | 28 ++
 rtl/csa_ks_packer.sv | 61 ++++++
 rtl/csa_sbox_collect.sv | 106 ++++++++++
 tb/tb_csa_sbox_collect.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the CSA s-box collector: default init length, FSM states
// and the s-box-bit to X/Y/Z nibble mapping.
package csa_pkg;

  localparam int CSA_INIT_ROUNDS = 32;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN
  } state_e;

  function automatic logic [3:0] map_x(input logic s4_0, input logic s3_1,
                                       input logic s2_1, input logic s1_0);
    return {s4_0, s3_1, s2_1, s1_0};
  endfunction

  function automatic logic [3:0] map_y(input logic s6_0, input logic s5_0,
                                       input logic s4_1, input logic s3_0);
    return {s6_0, s5_0, s4_1, s3_0};
  endfunction

  function automatic logic [3:0] map_z(input logic s7_1, input logic s6_1,
                                       input logic s2_0, input logic s1_1);
    return {s7_1, s6_1, s2_0, s1_1};
  endfunction

endpackage

// File: rtl/csa_ks_packer.sv
// Packs keystream dibits MSB-first into bytes and holds each byte on a
// valid/ready output register until the consumer takes it.
module csa_ks_packer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  logic [1:0] ks,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       out_stall
);

  logic [5:0] pack_q, pack_d;
  logic [1:0] dibit_cnt_q, dibit_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_comb begin
    pack_d      = pack_q;
    dibit_cnt_d = dibit_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    if (valid_q && m_ready) valid_d = 1'b0;
    if (push) begin
      pack_d      = {pack_q[3:0], ks};
      dibit_cnt_d = dibit_cnt_q + 2'd1;
      // A load on the drain edge overrides the clear above, so no byte is lost.
      if (dibit_cnt_q == 2'd3) begin
        data_d  = {pack_q, ks};
        valid_d = 1'b1;
      end
    end
    if (clear) begin
      pack_d      = '0;
      dibit_cnt_d = '0;
      data_d      = '0;
      valid_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pack_q      <= '0;
      dibit_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      pack_q      <= pack_d;
      dibit_cnt_q <= dibit_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign out_stall = valid_q && !m_ready;

endmodule

// File: rtl/csa_sbox_collect.sv
// Collects the seven CSA s-box outputs per round, feeds X/Y/Z back to the core and
// turns the folded X^Y^Z dibits into keystream bytes after an init phase.
module csa_sbox_collect
  import csa_pkg::*;
#(
  parameter int INIT_ROUNDS = CSA_INIT_ROUNDS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] s1,
  input  logic [1:0] s2,
  input  logic [1:0] s3,
  input  logic [1:0] s4,
  input  logic [1:0] s5,
  input  logic [1:0] s6,
  input  logic [1:0] s7,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [3:0] x_o,
  output logic [3:0] y_o,
  output logic [3:0] z_o,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy
);

  localparam int RW = $clog2(INIT_ROUNDS + 1);
  localparam logic [RW-1:0] LAST_INIT = RW'(INIT_ROUNDS - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] round_cnt_q, round_cnt_d;
  logic [3:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic [3:0]    xn, yn, zn, d;
  logic [1:0]    ks;
  logic          accept, push, out_stall;
  logic          unused_bits;

  assign xn = map_x(s4[0], s3[1], s2[1], s1[0]);
  assign yn = map_y(s6[0], s5[0], s4[1], s3[0]);
  assign zn = map_z(s7[1], s6[1], s2[0], s1[1]);
  assign d  = xn ^ yn ^ zn;
  assign ks = d[3:2] ^ d[1:0];
  assign unused_bits = s5[1] ^ s7[0];

  // start wins over a same-cycle round: the round is neither counted nor latched.
  assign s_ready = (state_q != IDLE) && !out_stall;
  assign accept  = s_valid && s_ready && !start;
  assign push    = accept && (state_q == RUN);
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    if (start) begin
      state_d     = INIT;
      round_cnt_d = '0;
    end else if (accept) begin
      x_d = xn;
      y_d = yn;
      z_d = zn;
      // Counter only advances in INIT, so it parks at INIT_ROUNDS once in RUN.
      if (state_q == INIT) begin
        round_cnt_d = round_cnt_q + 1'b1;
        if (round_cnt_q == LAST_INIT) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_cnt_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign z_o = z_q;

  csa_ks_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start),
    .push     (push),
    .ks       (ks),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .out_stall(out_stall)
  );

endmodule

// File: tb/tb_csa_sbox_collect.sv
// Directed bench: a short-init instance (INIT_ROUNDS=2) and a default instance,
// with per-instance expected-byte queues checked when each byte is handed over.
`timescale 1ns/1ps
module tb_csa_sbox_collect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b, s_valid_a, s_valid_b, m_ready_a, m_ready_b;
  logic [13:0] sbus;
  logic        s_ready_a, m_valid_a, busy_a, s_ready_b, m_valid_b, busy_b;
  logic [3:0]  x_a, y_a, z_a, x_b, y_b, z_b;
  logic [7:0]  m_data_a, m_data_b;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  localparam logic [13:0] S_ZERO = 14'h0000;
  localparam logic [13:0] S1_01  = 14'h0001;
  localparam logic [13:0] S1_11  = 14'h0003;
  localparam logic [13:0] S4_11  = 14'h00C0;

  csa_sbox_collect #(.INIT_ROUNDS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .s1(sbus[1:0]), .s2(sbus[3:2]), .s3(sbus[5:4]), .s4(sbus[7:6]),
    .s5(sbus[9:8]), .s6(sbus[11:10]), .s7(sbus[13:12]),
    .s_valid(s_valid_a), .s_ready(s_ready_a),
    .x_o(x_a), .y_o(y_a), .z_o(z_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a), .busy(busy_a)
  );

  csa_sbox_collect dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .s1(sbus[1:0]), .s2(sbus[3:2]), .s3(sbus[5:4]), .s4(sbus[7:6]),
    .s5(sbus[9:8]), .s6(sbus[11:10]), .s7(sbus[13:12]),
    .s_valid(s_valid_b), .s_ready(s_ready_b),
    .x_o(x_b), .y_o(y_b), .z_o(z_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one round and hold it until the selected instance accepts it.
  task automatic send(input bit to_b, input logic [13:0] s);
    int   n = 0;
    logic rdy;
    sbus = s;
    if (to_b) s_valid_b = 1'b1; else s_valid_a = 1'b1;
    #1;
    rdy = to_b ? s_ready_b : s_ready_a;
    while (!rdy && n < 20) begin
      tick();
      n++;
      rdy = to_b ? s_ready_b : s_ready_a;
    end
    if (!rdy) check(to_b ? "b_send_timeout" : "a_send_timeout", {31'b0, rdy}, 1);
    else tick();
    s_valid_a = 1'b0;
    s_valid_b = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid_a === 1'b1 && m_ready_a === 1'b1) begin
      $display("A byte out 0x%02h (expected queue depth %0d)", m_data_a, q_a.size());
      check("a_sb_has_entry", {31'b0, q_a.size() != 0}, 1);
      if (q_a.size() != 0) check("a_byte", {24'b0, m_data_a}, {24'b0, q_a.pop_front()});
    end
    if (rst_n === 1'b1 && m_valid_b === 1'b1 && m_ready_b === 1'b1) begin
      $display("B byte out 0x%02h (expected queue depth %0d)", m_data_b, q_b.size());
      check("b_sb_has_entry", {31'b0, q_b.size() != 0}, 1);
      if (q_b.size() != 0) check("b_byte", {24'b0, m_data_b}, {24'b0, q_b.pop_front()});
    end
  end

  initial begin
    int seen;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    s_valid_a = 1'b1; s_valid_b = 1'b1; m_ready_a = 1'b0; m_ready_b = 1'b0;
    sbus = S1_11;

    // Reset with rounds offered
    repeat (2) tick();
    check("rst_x", {28'b0, x_a}, 0);
    check("rst_y", {28'b0, y_a}, 0);
    check("rst_z", {28'b0, z_a}, 0);
    check("rst_m_data", {24'b0, m_data_a}, 0);
    check("rst_m_valid", {31'b0, m_valid_a}, 0);
    check("rst_s_ready", {31'b0, s_ready_a}, 0);
    check("rst_busy", {31'b0, busy_a}, 0);
    check("rst_b_m_valid", {31'b0, m_valid_b}, 0);
    check("rst_b_busy", {31'b0, busy_b}, 0);
    rst_n = 1'b1;
    tick();
    check("idle_s_ready", {31'b0, s_ready_a}, 0);
    check("idle_x_ignored", {28'b0, x_a}, 0);
    s_valid_a = 1'b0; s_valid_b = 1'b0;

    // Packing with INIT_ROUNDS=2
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("start_busy", {31'b0, busy_a}, 1);
    check("start_s_ready", {31'b0, s_ready_a}, 1);
    send(0, S_ZERO); send(0, S_ZERO);
    send(0, S1_01); send(0, S1_01); send(0, S1_01);
    check("pack_not_yet", {31'b0, m_valid_a}, 0);
    q_a.push_back(8'h55);
    send(0, S1_01);
    check("pack_x", {28'b0, x_a}, 4'h1);
    check("pack_y", {28'b0, y_a}, 0);
    check("pack_z", {28'b0, z_a}, 0);
    check("pack_m_valid", {31'b0, m_valid_a}, 1);
    check("pack_m_data", {24'b0, m_data_a}, 8'h55);

    // Back-pressure: pending byte blocks rounds, then drain and accept on one edge
    sbus = S4_11; s_valid_a = 1'b1;
    #1;
    check("bp_s_ready_low", {31'b0, s_ready_a}, 0);
    repeat (3) tick();
    check("bp_data_stable", {24'b0, m_data_a}, 8'h55);
    check("bp_valid_held", {31'b0, m_valid_a}, 1);
    check("bp_x_held", {28'b0, x_a}, 4'h1);
    m_ready_a = 1'b1;
    send(0, S4_11);
    check("bp_drained", {31'b0, m_valid_a}, 0);

    // Cancellation: s4=11 gives X=8, Y=2, keystream 00
    check("cancel_x", {28'b0, x_a}, 4'h8);
    check("cancel_y", {28'b0, y_a}, 4'h2);
    check("cancel_z", {28'b0, z_a}, 0);
    q_a.push_back(8'h00);
    send(0, S4_11); send(0, S4_11); send(0, S4_11);
    check("cancel_m_valid", {31'b0, m_valid_a}, 1);
    check("cancel_m_data", {24'b0, m_data_a}, 8'h00);
    tick();
    check("cancel_cleared", {31'b0, m_valid_a}, 0);

    // start drops a pending byte and ignores the offered round
    m_ready_a = 1'b0;
    send(0, S1_01); send(0, S1_01); send(0, S1_01); send(0, S1_01);
    check("drop_pending", {31'b0, m_valid_a}, 1);
    sbus = S4_11; s_valid_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0; s_valid_a = 1'b0;
    check("drop_m_valid", {31'b0, m_valid_a}, 0);
    check("drop_x_held", {28'b0, x_a}, 4'h1);
    check("drop_busy", {31'b0, busy_a}, 1);
    m_ready_a = 1'b1;

    // start mid-byte while a round would otherwise be accepted
    send(0, S1_01); send(0, S1_01);
    send(0, S1_01); send(0, S1_01);
    check("mid_no_byte", {31'b0, m_valid_a}, 0);
    sbus = S1_11; s_valid_a = 1'b1; start_a = 1'b1;
    #1;
    check("mid_s_ready", {31'b0, s_ready_a}, 1);
    tick();
    start_a = 1'b0; s_valid_a = 1'b0;
    check("mid_z_held", {28'b0, z_a}, 0);
    check("mid_x_held", {28'b0, x_a}, 4'h1);
    send(0, S1_01); send(0, S1_01);
    check("reinit_no_byte", {31'b0, m_valid_a}, 0);
    q_a.push_back(8'h00);
    send(0, S4_11); send(0, S4_11); send(0, S4_11);
    check("reinit_3_dibits", {31'b0, m_valid_a}, 0);
    send(0, S4_11);
    check("reinit_m_valid", {31'b0, m_valid_a}, 1);
    check("reinit_m_data", {24'b0, m_data_a}, 8'h00);
    tick();

    // Default 32-round init discard on the second instance
    m_ready_b = 1'b1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    seen = 0;
    for (int i = 0; i < 32; i++) begin
      send(1, S1_01);
      if (m_valid_b) seen++;
    end
    check("b_init_no_valid", seen, 0);
    check("b_busy", {31'b0, busy_b}, 1);
    q_b.push_back(8'h55);
    send(1, S1_01); send(1, S1_01); send(1, S1_01); send(1, S1_01);
    check("b_m_valid", {31'b0, m_valid_b}, 1);
    check("b_m_data", {24'b0, m_data_b}, 8'h55);
    tick();

    check("a_sb_drained", q_a.size(), 0);
    check("b_sb_drained", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
